// File: rtl/controlador_cruce.sv
// Two-way intersection controller: NS/EO vehicle lamps plus a pedestrian phase,
// sequenced on a prescaled tick with all-red clearance before every green.
module controlador_cruce #(
  parameter int unsigned TICK_DIV        = 500000,
  parameter int unsigned T_TODO_ROJO     = 1,
  parameter int unsigned T_ROJO_AMARILLO = 1,
  parameter int unsigned T_VERDE         = 8,
  parameter int unsigned T_VERDE_MIN     = 3,
  parameter int unsigned T_AMARILLO      = 2,
  parameter int unsigned T_PEATON        = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic boton_peaton,
  output logic rojo_ns,
  output logic amarillo_ns,
  output logic verde_ns,
  output logic rojo_eo,
  output logic amarillo_eo,
  output logic verde_eo,
  output logic peaton_verde,
  output logic peticion_pendiente
);

  typedef enum logic [3:0] {
    TR_NS, RA_NS, V_NS, A_NS, TR_EO, RA_EO, V_EO, A_EO, PEATON
  } estado_t;

  estado_t     estado, estado_n;
  logic [23:0] pres;
  logic [7:0]  cnt;
  logic        tick, fin, verde_fase;

  function automatic logic [7:0] largo(estado_t e);
    case (e)
      TR_NS, TR_EO: largo = 8'(T_TODO_ROJO);
      RA_NS, RA_EO: largo = 8'(T_ROJO_AMARILLO);
      V_NS,  V_EO:  largo = 8'(T_VERDE);
      A_NS,  A_EO:  largo = 8'(T_AMARILLO);
      PEATON:       largo = 8'(T_PEATON);
      default:      largo = 8'd1;
    endcase
  endfunction

  // {rojo_ns, amarillo_ns, verde_ns, rojo_eo, amarillo_eo, verde_eo, peaton_verde}
  function automatic logic [6:0] lamparas(estado_t e);
    case (e)
      RA_NS:   lamparas = 7'b110_100_0;
      V_NS:    lamparas = 7'b001_100_0;
      A_NS:    lamparas = 7'b010_100_0;
      RA_EO:   lamparas = 7'b100_110_0;
      V_EO:    lamparas = 7'b100_001_0;
      A_EO:    lamparas = 7'b100_010_0;
      PEATON:  lamparas = 7'b100_100_1;
      default: lamparas = 7'b100_100_0;
    endcase
  endfunction

  assign tick       = (pres == 24'(TICK_DIV - 1));
  assign verde_fase = (estado == V_NS) || (estado == V_EO);

  always_comb begin
    // A pending request lets green end as soon as the minimum has elapsed.
    fin = tick && ((cnt == largo(estado) - 8'd1) ||
                   (verde_fase && peticion_pendiente && cnt >= 8'(T_VERDE_MIN - 1)));
    estado_n = estado;
    case (estado)
      TR_NS:  if (fin) estado_n = RA_NS;
      RA_NS:  if (fin) estado_n = V_NS;
      V_NS:   if (fin) estado_n = A_NS;
      A_NS:   if (fin) estado_n = TR_EO;
      TR_EO:  if (fin) estado_n = RA_EO;
      RA_EO:  if (fin) estado_n = V_EO;
      V_EO:   if (fin) estado_n = A_EO;
      A_EO:   if (fin) estado_n = peticion_pendiente ? PEATON : TR_NS;
      PEATON: if (fin) estado_n = TR_NS;
      default: begin
        fin = tick;
        if (tick) estado_n = TR_NS;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado             <= TR_NS;
      pres               <= '0;
      cnt                <= '0;
      peticion_pendiente <= 1'b0;
      {rojo_ns, amarillo_ns, verde_ns, rojo_eo, amarillo_eo, verde_eo, peaton_verde}
                         <= 7'b100_100_0;
    end else begin
      pres   <= tick ? 24'd0 : pres + 24'd1;
      if (tick) cnt <= fin ? 8'd0 : cnt + 8'd1;
      estado <= estado_n;
      // Lamps decode from the next state so they change with the state register.
      {rojo_ns, amarillo_ns, verde_ns, rojo_eo, amarillo_eo, verde_eo, peaton_verde}
             <= lamparas(estado_n);
      if (estado_n == PEATON && estado != PEATON)
        peticion_pendiente <= 1'b0;
      else if (boton_peaton && estado != PEATON)
        peticion_pendiente <= 1'b1;
    end
  end

endmodule

// File: tb/tb_controlador_cruce.sv
// Scoreboard bench: a tick-level schedule model predicts every output cycle by cycle.
module tb_controlador_cruce;
  localparam int TD = 4, TTR = 1, TRA = 1, TV = 4, TVMIN = 2, TA = 2, TP = 3;

  logic clk = 1'b0;
  logic rst, boton;
  logic rojo_ns, amarillo_ns, verde_ns, rojo_eo, amarillo_eo, verde_eo;
  logic peaton_verde, peticion_pendiente;

  controlador_cruce #(
    .TICK_DIV(TD), .T_TODO_ROJO(TTR), .T_ROJO_AMARILLO(TRA), .T_VERDE(TV),
    .T_VERDE_MIN(TVMIN), .T_AMARILLO(TA), .T_PEATON(TP)
  ) dut (
    .clk(clk), .rst(rst), .boton_peaton(boton),
    .rojo_ns(rojo_ns), .amarillo_ns(amarillo_ns), .verde_ns(verde_ns),
    .rojo_eo(rojo_eo), .amarillo_eo(amarillo_eo), .verde_eo(verde_eo),
    .peaton_verde(peaton_verde), .peticion_pendiente(peticion_pendiente)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [7:0] expq[$];

  // Phases in schedule order: 0 TR_NS .. 7 A_EO, 8 pedestrian walk.
  int ph, el, cyc;
  bit pend;

  function automatic int len(input int p);
    case (p)
      0, 4:    return TTR;
      1, 5:    return TRA;
      2, 6:    return TV;
      3, 7:    return TA;
      default: return TP;
    endcase
  endfunction

  function automatic logic [6:0] lamps(input int p);
    case (p)
      1:       return 7'b110_100_0;
      2:       return 7'b001_100_0;
      3:       return 7'b010_100_0;
      5:       return 7'b100_110_0;
      6:       return 7'b100_001_0;
      7:       return 7'b100_010_0;
      8:       return 7'b100_100_1;
      default: return 7'b100_100_0;
    endcase
  endfunction

  function automatic logic [7:0] outs();
    return {rojo_ns, amarillo_ns, verde_ns, rojo_eo, amarillo_eo, verde_eo,
            peaton_verde, peticion_pendiente};
  endfunction

  // Predict the state held after the coming posedge, given this cycle's button.
  task automatic model_step(input bit b);
    bit tk, go;
    int prev;
    tk = (cyc % TD) == TD - 1;
    cyc++;
    go = 1'b0;
    prev = ph;
    if (tk) begin
      el++;
      if (el == len(ph) || ((ph == 2 || ph == 6) && pend && el >= TVMIN)) begin
        if (ph == 7) begin go = pend; ph = pend ? 8 : 0; end
        else if (ph == 8) ph = 0;
        else ph++;
        el = 0;
      end
    end
    if (go) pend = 1'b0;
    else if (b && prev != 8) pend = 1'b1;
    expq.push_back({lamps(ph), pend});
  endtask

  task automatic step(input bit b);
    boton = b;
    model_step(b);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    boton = 1'b0;
    #1;
    tests++;
    if (outs() !== 8'b100_100_0_0) begin
      fails++;
      $display("FAIL async_reset got=%b exp=%b", outs(), 8'b100_100_0_0);
    end
    ph = 0; el = 0; cyc = 0; pend = 1'b0;
    expq.push_back({lamps(0), 1'b0});
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic timeout(input string what);
    fails++;
    $display("FAIL timeout_%s got=expired exp=reached", what);
  endtask

  // Monitor: one expected word per posedge, plus the lamp safety rules.
  initial begin
    logic [7:0] e;
    bit ok;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        tests++;
        if (outs() !== e) begin
          fails++;
          $display("FAIL outputs t=%0t got=%b exp=%b", $time, outs(), e);
        end
        ok = !((verde_ns | amarillo_ns) & (verde_eo | amarillo_eo)) &&
             (!peaton_verde || (rojo_ns && rojo_eo)) && (rojo_ns || rojo_eo);
        tests++;
        if (!ok) begin
          fails++;
          $display("FAIL safety t=%0t got=%b exp=safe", $time, outs());
        end
      end
    end
  end

  initial begin
    int g;
    rst = 1'b1;
    boton = 1'b0;
    @(negedge clk);

    // Reset, first phase and two full rotations without requests.
    do_reset();
    repeat (140) step(1'b0);

    // Press at cycle 9 in V_NS, then a press during the walk phase.
    do_reset();
    repeat (9) step(1'b0);
    step(1'b1);
    g = 0;
    while (ph != 8 && g < 200) begin step(1'b0); g++; end
    if (g >= 200) timeout("peaton");
    step(1'b1);
    repeat (80) step(1'b0);

    // Late request: EO green already at counter 3.
    g = 0;
    while (!(ph == 6 && el == 3) && g < 200) begin step(1'b0); g++; end
    if (g >= 200) timeout("late_req");
    step(1'b1);
    repeat (40) step(1'b0);

    // Reset in the middle of EO green, then restart.
    g = 0;
    while (ph != 6 && g < 200) begin step(1'b0); g++; end
    if (g >= 200) timeout("v_eo");
    repeat (5) step(1'b0);
    do_reset();
    repeat (40) step(1'b0);

    // Random presses with occasional resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else step($urandom_range(0, 14) == 0);
    end

    boton = 1'b0;
    @(posedge clk);
    #2;
    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d exp=0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
